// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a shared barrel shifter (SLL/SRL/SRA).
// One accepted operation per cycle; the result is held in a single response register.
module shift_arbiter #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [SHW-1:0]   req0_s,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [SHW-1:0]   req1_s,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             rr_ptr_reg, rr_ptr_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             id_reg, id_next;
    logic             err_reg, err_next;

    logic             free;
    logic             grant;
    logic             accept;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [SHW-1:0]   sel_s;

    logic [WIDTH-1:0] rev_in;
    logic [WIDTH-1:0] rev_out;
    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] stage [0:SHW];
    logic             fill;
    logic [WIDTH-1:0] result;

    // Readies depend only on valids, rr pointer and response-slot state, never on each other.
    always_comb begin
        free   = (state_reg == EMPTY) || rsp_ready;
        grant  = (req0_valid && req1_valid) ? rr_ptr_reg : req1_valid;
        accept = !rst && free && (req0_valid || req1_valid);
        req0_ready = accept && (grant == 1'b0);
        req1_ready = accept && (grant == 1'b1);
    end

    always_comb begin
        sel_op = grant ? req1_op : req0_op;
        sel_a  = grant ? req1_a  : req0_a;
        sel_s  = grant ? req1_s  : req0_s;
    end

    // Left shifts reuse the right-shift network on the bit-reversed operand.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign rev_in[gi]  = sel_a[WIDTH-1-gi];
            assign rev_out[gi] = stage[SHW][WIDTH-1-gi];
        end
    endgenerate

    assign shift_in = (sel_op == OP_SLL) ? rev_in : sel_a;
    assign fill     = (sel_op == OP_SRA) && sel_a[WIDTH-1];
    assign stage[0] = shift_in;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = sel_s[gi] ? {{SH{fill}}, stage[gi][WIDTH-1:SH]} : stage[gi];
        end
    endgenerate

    always_comb begin
        case (sel_op)
            OP_SLL:  result = rev_out;
            OP_SRL:  result = stage[SHW];
            OP_SRA:  result = stage[SHW];
            default: result = sel_a;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        data_next   = data_reg;
        id_next     = id_reg;
        err_next    = err_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (!accept && rsp_ready) begin
                    state_next = EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (accept) begin
            data_next   = result;
            id_next     = grant;
            err_next    = (sel_op == 2'b11);
            rr_ptr_next = ~grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= EMPTY;
            rr_ptr_reg <= 1'b0;
            data_reg   <= '0;
            id_reg     <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            data_reg   <= data_next;
            id_reg     <= id_next;
            err_reg    <= err_next;
        end
    end

    assign rsp_valid = (state_reg == FULL);
    assign rsp_id    = id_reg;
    assign rsp_data  = data_reg;
    assign rsp_err   = err_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: directed scenarios followed by randomized traffic.
module tb_shift_arbiter;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [1:0]       req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0] req0_a = '0, req1_a = '0;
    logic [SHW-1:0]   req0_s = '0, req1_s = '0;
    logic             rsp_valid, rsp_ready = 1'b0;
    logic             rsp_id, rsp_err;
    logic [WIDTH-1:0] rsp_data;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic             id;
        logic             err;
        logic [WIDTH-1:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    logic m_valid = 1'b0;
    logic m_rr    = 1'b0;

    shift_arbiter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_s(req0_s),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_s(req1_s),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference shift computed directly from the arithmetic definition of each op.
    function automatic rsp_t ref_op(input logic id, input logic [1:0] op,
                                    input logic [WIDTH-1:0] a, input logic [SHW-1:0] s);
        rsp_t r;
        r.id  = id;
        r.err = (op == 2'b11);
        case (op)
            2'b00:   r.data = a << s;
            2'b01:   r.data = a >> s;
            2'b10:   r.data = $unsigned($signed(a) >>> s);
            default: r.data = a;
        endcase
        return r;
    endfunction

    // Monitor: predicts readies, pushes expected results on handshake, compares held response.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_valid = 1'b0;
            m_rr    = 1'b0;
        end else begin
            logic free_e, grant_e, hs0, hs1;
            rsp_t exp_r;
            free_e  = !m_valid || rsp_ready;
            grant_e = (req0_valid && req1_valid) ? m_rr : req1_valid;
            chk("ready_excl", {31'd0, req0_ready && req1_ready}, 32'd0);
            chk("req0_ready", {31'd0, req0_ready}, {31'd0, free_e && req0_valid && !grant_e});
            chk("req1_ready", {31'd0, req1_ready}, {31'd0, free_e && req1_valid && grant_e});
            chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_r = sb_q[0];
                    chk("rsp_id", {31'd0, rsp_id}, {31'd0, exp_r.id});
                    chk("rsp_data", rsp_data, exp_r.data);
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_r.err});
                    if (rsp_ready) void'(sb_q.pop_front());
                end
            end
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            if (hs0) sb_q.push_back(ref_op(1'b0, req0_op, req0_a, req0_s));
            if (hs1) sb_q.push_back(ref_op(1'b1, req1_op, req1_a, req1_s));
            if (hs0 || hs1) begin
                m_valid = 1'b1;
                m_rr    = hs0 ? 1'b1 : 1'b0;
            end else if (rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
        req0_valid = v; req0_op = op; req0_a = a; req0_s = s;
    endtask

    task automatic set1(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [4:0] s);
        req1_valid = v; req1_op = op; req1_a = a; req1_s = s;
    endtask

    initial begin
        logic hs0, hs1;
        // Reset state, readies low while rst is asserted even with a request pending.
        repeat (2) cyc();
        set0(1'b1, 2'b10, 32'h8000_0010, 5'd4);
        rsp_ready = 1'b1;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("sra_ready", {31'd0, req0_ready}, 32'd1);
        cyc();
        set0(1'b0, 2'b00, 32'd0, 5'd0);
        chk("sra_valid", {31'd0, rsp_valid}, 32'd1);
        chk("sra_data", rsp_data, 32'hF800_0001);
        chk("sra_id", {31'd0, rsp_id}, 32'd0);

        // Bring the pointer back to requester 0, then run both continuously.
        set1(1'b1, 2'b01, 32'h1, 5'd0);
        cyc();
        set1(1'b0, 2'b00, 32'd0, 5'd0);
        set0(1'b1, 2'b00, 32'h1, 5'd31);
        set1(1'b1, 2'b01, 32'h8000_0000, 5'd31);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fair_grant", {31'd0, (i % 2 == 0) ? req0_ready : req1_ready}, 32'd1);
            cyc();
            chk("fair_id", {31'd0, rsp_id}, i % 2);
            chk("fair_data", rsp_data, (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_0001);
        end
        set0(1'b0, 2'b00, 32'd0, 5'd0);
        set1(1'b0, 2'b00, 32'd0, 5'd0);
        cyc();

        // Backpressure: held response blocks requester 0 until the consumer drains.
        set1(1'b1, 2'b00, 32'hF, 5'd4);
        cyc();
        set1(1'b0, 2'b00, 32'd0, 5'd0);
        rsp_ready = 1'b0;
        set0(1'b1, 2'b01, 32'h100, 5'd4);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready0", {31'd0, req0_ready}, 32'd0);
            chk("bp_data", rsp_data, 32'hF0);
            chk("bp_id", {31'd0, rsp_id}, 32'd1);
            cyc();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, req0_ready}, 32'd1);
        cyc();
        set0(1'b0, 2'b00, 32'd0, 5'd0);
        chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp_new_data", rsp_data, 32'h10);

        // Reserved op passes operand through and flags error; s=0 leaves operand unchanged.
        set0(1'b1, 2'b11, 32'h1234_5678, 5'd7);
        cyc();
        chk("res_data", rsp_data, 32'h1234_5678);
        chk("res_err", {31'd0, rsp_err}, 32'd1);
        set0(1'b1, 2'b01, 32'hDEAD_BEEF, 5'd0);
        cyc();
        set0(1'b0, 2'b00, 32'd0, 5'd0);
        chk("s0_data", rsp_data, 32'hDEAD_BEEF);
        chk("s0_err", {31'd0, rsp_err}, 32'd0);
        cyc();

        // Asynchronous reset between edges drops the held response immediately.
        rsp_ready = 1'b0;
        set1(1'b1, 2'b00, 32'h3, 5'd1);
        cyc();
        set1(1'b0, 2'b00, 32'd0, 5'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        cyc();
        set0(1'b1, 2'b00, 32'h5, 5'd2);
        set1(1'b1, 2'b01, 32'h5, 5'd2);
        rsp_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("arst_grant0", {31'd0, req0_ready}, 32'd1);
        chk("arst_grant1", {31'd0, req1_ready}, 32'd0);
        cyc();
        set0(1'b0, 2'b00, 32'd0, 5'd0);
        set1(1'b0, 2'b00, 32'd0, 5'd0);
        chk("arst_id", {31'd0, rsp_id}, 32'd0);
        chk("arst_data", rsp_data, 32'h14);
        repeat (2) cyc();

        // Random traffic; requesters hold their operation until accepted.
        hs0 = 1'b0;
        hs1 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!req0_valid || hs0)
                set0($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            if (!req1_valid || hs1)
                set1($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
            rsp_ready = $urandom_range(0, 3) != 0;
            #3;
            hs0 = req0_valid && req0_ready;
            hs1 = req1_valid && req1_ready;
            cyc();
        end
        set0(1'b0, 2'b00, 32'd0, 5'd0);
        set1(1'b0, 2'b00, 32'd0, 5'd0);
        rsp_ready = 1'b1;
        repeat (4) cyc();
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
